// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported memory.
// Optional BUSY timeout with error reporting is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 (CPU data port)
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_ack,
  output logic              r0_err,
  // requester 1 (DMA/debug port)
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_ack,
  output logic              r1_err,
  // shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0]   r1_rdata_q, r1_rdata_d;

  logic act0, act1, pick1;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign act0  = r0_read | r0_write;
  assign act1  = r1_read | r1_write;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1 = act1 & (~act0 | ~last_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
`ifdef ARB_TIMEOUT_EN
    err_d      = err_q;
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (act0 || act1) begin
          state_d = BUSY;
          gnt_d   = pick1;
          wr_d    = pick1 ? r1_write : r0_write;
          addr_d  = pick1 ? r1_addr  : r0_addr;
          wdata_d = pick1 ? r1_wdata : r0_wdata;
`ifdef ARB_TIMEOUT_EN
          err_d   = 1'b0;
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = DONE;
          last_d  = gnt_q;
          if (!wr_q) begin
            if (gnt_q) r1_rdata_d = mem_rdata;
            else       r0_rdata_d = mem_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Give up: complete with an error and zeroed read data.
          state_d = DONE;
          last_d  = gnt_q;
          err_d   = 1'b1;
          if (gnt_q) r1_rdata_d = '0;
          else       r0_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign r0_err = (state_q == DONE) & ~gnt_q & err_q;
  assign r1_err = (state_q == DONE) &  gnt_q & err_q;
`else
  assign r0_err = 1'b0;
  assign r1_err = 1'b0;
`endif

  assign mem_read  = (state_q == BUSY) & ~wr_q;
  assign mem_write = (state_q == BUSY) &  wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign r0_ack    = (state_q == DONE) & ~gnt_q;
  assign r1_ack    = (state_q == DONE) &  gnt_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout case runs when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [31:0] r0_rdata, r1_rdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic        mem_read, mem_write, mem_ready, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] exp_r0_rdata = '0;
  logic [31:0] exp_r1_rdata = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .r0_read(r0_read), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_rdata(r0_rdata), .r0_ack(r0_ack), .r0_err(r0_err),
    .r1_read(r1_read), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_rdata(r1_rdata), .r1_ack(r1_ack), .r1_err(r1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  busy,      1'b0);
    check({tag, ".r0ack"}, r0_ack,    1'b0);
    check({tag, ".r1ack"}, r1_ack,    1'b0);
    check({tag, ".mrd"},   mem_read,  1'b0);
    check({tag, ".mwr"},   mem_write, 1'b0);
  endtask

  // Requests are already driven in IDLE; run one grant through to the DONE cycle.
  task automatic serve(input string tag, input bit who, input logic [31:0] exp_addr,
                       input bit exp_wr, input logic [31:0] exp_wdata,
                       input logic [31:0] rd, input int waits, input bit perturb);
    mem_ready = 1'b0;
    mem_rdata = rd;
    tick();
    if (perturb) begin
      if (who) begin
        r1_addr = ~r1_addr; r1_wdata = ~r1_wdata; r1_write = ~r1_write;
      end else begin
        r0_addr = ~r0_addr; r0_wdata = ~r0_wdata; r0_write = ~r0_write;
      end
    end
    for (int i = 0; i <= waits; i++) begin
      check({tag, ".busy"},  busy,      1'b1);
      check({tag, ".mrd"},   mem_read,  !exp_wr);
      check({tag, ".mwr"},   mem_write, exp_wr);
      check({tag, ".maddr"}, mem_addr,  exp_addr);
      if (exp_wr) check({tag, ".mwdata"}, mem_wdata, exp_wdata);
      check({tag, ".acks"},  {r0_ack, r1_ack}, 2'b00);
      if (i == waits) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    if (!exp_wr) begin
      if (who) exp_r1_rdata = rd;
      else     exp_r0_rdata = rd;
    end
    check({tag, ".r0ack"},  r0_ack,   !who);
    check({tag, ".r1ack"},  r1_ack,   who);
    check({tag, ".errs"},   {r0_err, r1_err}, 2'b00);
    check({tag, ".strobe"}, {mem_read, mem_write}, 2'b00);
    check({tag, ".dbusy"},  busy,     1'b1);
    check({tag, ".r0rd"},   r0_rdata, exp_r0_rdata);
    check({tag, ".r1rd"},   r1_rdata, exp_r1_rdata);
    $display("txn %s: req%0d %s addr=0x%0h waits=%0d", tag, who, exp_wr ? "write" : "read",
             exp_addr, waits);
  endtask

  task automatic to_idle(input string tag);
    tick();
    check_idle(tag);
  endtask

  initial begin
    rst = 1'b0;
    {r0_read, r0_write, r1_read, r1_write, mem_ready} = '0;
    {r0_addr, r0_wdata, r1_addr, r1_wdata, mem_rdata} = '0;
    tick();
    tick();
    check_idle("reset");
    check("reset.maddr", mem_addr, 32'h0);
    check("reset.mwdata", mem_wdata, 32'h0);
    check("reset.rdata", {r0_rdata, r1_rdata}, 64'h0);
    check("reset.errs", {r0_err, r1_err}, 2'b00);
    rst = 1'b1;
    tick();

    // Zero-wait read: strobe at N+1, ack at N+2.
    r0_read = 1'b1; r0_addr = 32'h10;
    check_idle("rd0.pre");
    serve("rd0", 1'b0, 32'h10, 1'b0, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    r0_read = 1'b0;
    to_idle("rd0.post");

    // Read and write together: write wins.
    r0_read = 1'b1; r0_write = 1'b1; r0_addr = 32'h30; r0_wdata = 32'h1234;
    serve("rw0", 1'b0, 32'h30, 1'b1, 32'h1234, 32'h0BAD0BAD, 0, 1'b0);
    r0_read = 1'b0; r0_write = 1'b0;
    to_idle("rw0.post");

    // Fresh reset, then both held: grants alternate r0, r1, r0, r1.
    rst = 1'b0; #2; rst = 1'b1;
    exp_r0_rdata = '0; exp_r1_rdata = '0;
    check("rst2.rdata", {r0_rdata, r1_rdata}, 64'h0);
    r0_write = 1'b1; r0_addr = 32'h100; r0_wdata = 32'hA0;
    r1_read  = 1'b1; r1_addr = 32'h200;
    serve("rr1", 1'b0, 32'h100, 1'b1, 32'hA0, 32'h0BAD, 0, 1'b0);
    r0_write = 1'b0; r0_read = 1'b1; r0_addr = 32'h104;
    to_idle("rr1.post");
    serve("rr2", 1'b1, 32'h200, 1'b0, 32'h0, 32'h11112222, 0, 1'b0);
    r1_addr = 32'h204;
    to_idle("rr2.post");
    serve("rr3", 1'b0, 32'h104, 1'b0, 32'h0, 32'h33334444, 0, 1'b0);
    r0_read = 1'b0;
    to_idle("rr3.post");
    serve("rr4", 1'b1, 32'h204, 1'b0, 32'h0, 32'h55556666, 0, 1'b0);
    r1_read = 1'b0;
    to_idle("rr4.post");

    // Write with three wait states: strobe and bus stable for four cycles.
    r1_write = 1'b1; r1_addr = 32'h20; r1_wdata = 32'h55AA;
    serve("ws1", 1'b1, 32'h20, 1'b1, 32'h55AA, 32'hFFFFFFFF, 3, 1'b0);
    r1_write = 1'b0;
    to_idle("ws1.post");

    // Request changes during BUSY must not disturb the latched transaction.
    r0_read = 1'b1; r0_addr = 32'h44; r0_wdata = 32'h0;
    serve("chg", 1'b0, 32'h44, 1'b0, 32'h0, 32'hCAFEF00D, 2, 1'b1);
    r0_read = 1'b0; r0_write = 1'b0;
    to_idle("chg.post");

    // mem_ready in IDLE is ignored.
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) to_idle("rdyidle");
    mem_ready = 1'b0;

    // Reset during BUSY: everything drops at once, no ack afterwards.
    r1_read = 1'b1; r1_addr = 32'h300;
    tick();
    check("rstbusy.mrd", mem_read, 1'b1);
    rst = 1'b0; #1;
    check("rstbusy.strobe", {mem_read, mem_write}, 2'b00);
    check("rstbusy.busy", busy, 1'b0);
    check("rstbusy.maddr", mem_addr, 32'h0);
    check("rstbusy.rdata", {r0_rdata, r1_rdata}, 64'h0);
    exp_r0_rdata = '0; exp_r1_rdata = '0;
    r1_read = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) to_idle("rstrel");

    // Pointer reset: requester 0 wins the first tie.
    r0_read = 1'b1; r0_addr = 32'h400;
    r1_read = 1'b1; r1_addr = 32'h500;
    serve("tie", 1'b0, 32'h400, 1'b0, 32'h0, 32'h77778888, 0, 1'b0);
    r0_read = 1'b0;
    to_idle("tie.post");
    serve("tie2", 1'b1, 32'h500, 1'b0, 32'h0, 32'h9999AAAA, 1, 1'b0);
    r1_read = 1'b0;
    to_idle("tie2.post");

`ifdef ARB_TIMEOUT_EN
    // No mem_ready: 15 BUSY cycles, then ack with err and zeroed rdata.
    r0_read = 1'b1; r0_addr = 32'h600; mem_ready = 1'b0;
    tick();
    for (int i = 1; i <= 15; i++) begin
      check("tmo.mrd", mem_read, 1'b1);
      check("tmo.ack", r0_ack, 1'b0);
      tick();
    end
    check("tmo.strobe", mem_read, 1'b0);
    check("tmo.r0ack", r0_ack, 1'b1);
    check("tmo.r0err", r0_err, 1'b1);
    check("tmo.r1", {r1_ack, r1_err}, 2'b00);
    check("tmo.r0rd", r0_rdata, 32'h0);
    $display("txn tmo: req0 read addr=0x600 timed out");
    r0_read = 1'b0;
    to_idle("tmo.post");
    check("tmo.errclr", r0_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
